cordic_z_sequencer: RTL and testbench

CORDIC_Z_SEQUENCER -- requirements
Module: cordic_z_sequencer

---
 rtl/cordic_z_sequencer_pkg.sv | 16 +
 rtl/cordic_z_sequencer.sv | 138 +++++++++++++
 tb/tb_cordic_z_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_z_sequencer_pkg.sv
// Shared CORDIC definitions: Z-sequencer FSM encoding and default iteration count.
package cordic_z_sequencer_pkg;

   // Number of LUT addresses walked per run unless overridden.
   localparam int N_ITER_DEFAULT = 25;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_LOAD     = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_WAIT_ACK = 3'd4,
      ST_FIN      = 3'd5
   } state_t;

endpackage

// File: rtl/cordic_z_sequencer.sv
// CORDIC Z-path sequencer: walks the arctangent LUT, sign-adjusts each word with
// the iteration direction bit and hands it to the FP adder with a start pulse,
// waiting for the adder's acknowledge before moving on.
module cordic_z_sequencer
   import cordic_z_sequencer_pkg::*;
#(
   parameter int P      = 32,
   parameter int D      = 5,
   parameter int N_ITER = N_ITER_DEFAULT
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         BEG_FSM,
   input  logic         SIGN_D,
   input  logic         ACK_ADD,
   input  logic [P-1:0] O_D,
   output logic         EN_ROM1,
   output logic [D-1:0] ADRS,
   output logic [P-1:0] Z_TERM,
   output logic         EN_ADD,
   output logic         BUSY,
   output logic         DONE
);

   // One extra counter bit so N_ITER = 2^D never aliases back to zero.
   localparam int             CW       = D + 1;
   localparam logic [CW-1:0]  LAST_IDX = CW'(N_ITER - 1);

   // Flip the sign bit of the LUT word when the rotation direction is negative.
   function automatic logic [P-1:0] sign_adjust(input logic [P-1:0] word, input logic dir);
      sign_adjust = {word[P-1] ^ dir, word[P-2:0]};
   endfunction

   state_t         state_r, state_s;
   logic [CW-1:0]  cnt_r, cnt_s, cnt_inc_s;
   logic           en_rom1_r, en_rom1_s;
   logic [D-1:0]   adrs_r, adrs_s;
   logic [P-1:0]   z_term_r, z_term_s;
   logic           en_add_r, en_add_s;
   logic           busy_r, busy_s;
   logic           done_r, done_s;

   assign cnt_inc_s = cnt_r + CW'(1);

   // Next-state logic; outputs are computed for the state being entered so the
   // registers present them during that state.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      en_rom1_s = 1'b0;
      adrs_s    = adrs_r;
      z_term_s  = z_term_r;
      en_add_s  = 1'b0;
      busy_s    = busy_r;
      done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (BEG_FSM) begin
               cnt_s     = {CW{1'b0}};
               adrs_s    = {D{1'b0}};
               en_rom1_s = 1'b1;
               busy_s    = 1'b1;
               state_s   = ST_FETCH;
            end else begin
               busy_s    = 1'b0;
            end
         end
         ST_FETCH: begin
            state_s = ST_LOAD;
         end
         ST_LOAD: begin
            // O_D is only valid now; the LUT clears it on the next edge.
            z_term_s = sign_adjust(O_D, SIGN_D);
            en_add_s = 1'b1;
            state_s  = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_s = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ACK_ADD) begin
               if (cnt_r == LAST_IDX) begin
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  state_s = ST_FIN;
               end else begin
                  cnt_s     = cnt_inc_s;
                  adrs_s    = cnt_inc_s[D-1:0];
                  en_rom1_s = 1'b1;
                  state_s   = ST_FETCH;
               end
            end else begin
               state_s = ST_WAIT_ACK;
            end
         end
         ST_FIN: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            cnt_s   = {CW{1'b0}};
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; reset clears any partial run.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         en_rom1_r <= 1'b0;
         adrs_r    <= {D{1'b0}};
         z_term_r  <= {P{1'b0}};
         en_add_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         en_rom1_r <= en_rom1_s;
         adrs_r    <= adrs_s;
         z_term_r  <= z_term_s;
         en_add_r  <= en_add_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign EN_ROM1 = en_rom1_r;
   assign ADRS    = adrs_r;
   assign Z_TERM  = z_term_r;
   assign EN_ADD  = en_add_r;
   assign BUSY    = busy_r;
   assign DONE    = done_r;

endmodule

// File: tb/tb_cordic_z_sequencer.sv
// Bench for cordic_z_sequencer: two instances (25 and 32 iterations) each with a
// registered LUT model; expected activity is a timeline derived from iteration
// counts and ACK delays, with Z terms computed from the LUT contents.
module tb_cordic_z_sequencer;

   logic        CLK;
   logic        RST;
   logic [1:0]  beg, sign, ack;
   logic [1:0]  en_rom1, en_add, busy, done;
   logic [4:0]  adrs   [2];
   logic [31:0] z_term [2];
   logic [31:0] o_d    [2];
   logic [31:0] lut    [32];
   logic [31:0] z0_obs;
   int          checks;
   int          errors;

   cordic_z_sequencer #(.P(32), .D(5), .N_ITER(25)) dut25 (
      .CLK(CLK), .RST(RST), .BEG_FSM(beg[0]), .SIGN_D(sign[0]), .ACK_ADD(ack[0]),
      .O_D(o_d[0]), .EN_ROM1(en_rom1[0]), .ADRS(adrs[0]), .Z_TERM(z_term[0]),
      .EN_ADD(en_add[0]), .BUSY(busy[0]), .DONE(done[0])
   );

   cordic_z_sequencer #(.P(32), .D(5), .N_ITER(32)) dut32 (
      .CLK(CLK), .RST(RST), .BEG_FSM(beg[1]), .SIGN_D(sign[1]), .ACK_ADD(ack[1]),
      .O_D(o_d[1]), .EN_ROM1(en_rom1[1]), .ADRS(adrs[1]), .Z_TERM(z_term[1]),
      .EN_ADD(en_add[1]), .BUSY(busy[1]), .DONE(done[1])
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Registered LUT: word valid the cycle after the read enable, zero otherwise.
   always @(posedge CLK) begin
      for (int g = 0; g < 2; g++) begin
         o_d[g] <= en_rom1[g] ? lut[adrs[g]] : 32'h0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int sel, input string tag);
      chk({tag, "_en_rom1"}, 64'(en_rom1[sel]), 64'd0);
      chk({tag, "_adrs"},    64'(adrs[sel]),    64'd0);
      chk({tag, "_z_term"},  64'(z_term[sel]),  64'd0);
      chk({tag, "_en_add"},  64'(en_add[sel]),  64'd0);
      chk({tag, "_busy"},    64'(busy[sel]),    64'd0);
      chk({tag, "_done"},    64'(done[sel]),    64'd0);
   endtask

   // One run: n iterations, optional ACK delay on one iteration, optional noise
   // on BEG_FSM/ACK_ADD, optional reset in the LOAD cycle of one iteration.
   task automatic run(input int sel, input int n, input int dly_iter, input int dly,
                      input bit noise, input int rst_iter, input int sign0);
      int          fetch_c [32];
      int          add_c   [32];
      bit          sign_tab[32];
      logic [31:0] exp_z   [32];
      int          extra, done_c, fk, ak, load_k, wait_k, last_k, last_a;
      extra = 0;
      for (int k = 0; k < n; k++) begin
         fetch_c[k]  = 1 + 4 * k + extra;
         add_c[k]    = fetch_c[k] + 2;
         if (k == dly_iter) extra += dly;
         sign_tab[k] = 1'($urandom_range(1, 0));
         if (k == 0 && sign0 >= 0) sign_tab[k] = sign0[0];
         exp_z[k]    = lut[k] ^ {sign_tab[k], 31'h0};
      end
      done_c = 4 * n + 1 + extra;
      last_k = -1;
      last_a = -1;

      @(negedge CLK);
      beg[sel]  = 1'b1;
      ack[sel]  = 1'b1;
      sign[sel] = 1'($urandom_range(1, 0));
      for (int cyc = 1; cyc <= done_c + 3; cyc++) begin
         @(negedge CLK);
         fk = -1; ak = -1; load_k = -1; wait_k = -1;
         for (int k = 0; k < n; k++) begin
            if (fetch_c[k] == cyc)     fk = k;
            if (fetch_c[k] + 1 == cyc) load_k = k;
            if (add_c[k] == cyc)       ak = k;
            if (add_c[k] + 1 == cyc)   wait_k = k;
         end
         chk($sformatf("en_rom1@%0d", cyc), 64'(en_rom1[sel]), 64'(fk >= 0));
         if (fk >= 0) begin
            last_k = fk;
            chk($sformatf("adrs@%0d", cyc), 64'(adrs[sel]), 64'(fk));
         end else if (last_k >= 0) begin
            chk($sformatf("adrs_hold@%0d", cyc), 64'(adrs[sel]), 64'(last_k));
         end
         chk($sformatf("en_add@%0d", cyc), 64'(en_add[sel]), 64'(ak >= 0));
         if (ak >= 0) last_a = ak;
         if (last_a >= 0) begin
            chk($sformatf("z_term@%0d", cyc), 64'(z_term[sel]), 64'(exp_z[last_a]));
         end
         if (ak == 0) z0_obs = z_term[sel];
         chk($sformatf("busy@%0d", cyc), 64'(busy[sel]), 64'(cyc < done_c));
         chk($sformatf("done@%0d", cyc), 64'(done[sel]), 64'(cyc == done_c));

         if (rst_iter >= 0 && load_k == rst_iter) begin
            RST = 1'b0;
            #1;
            chk_zero(sel, "midrun_rst");
            beg[sel] = 1'b0;
            return;
         end

         if (noise && cyc < done_c)       beg[sel] = 1'($urandom_range(1, 0));
         else if (noise && cyc == done_c) beg[sel] = 1'b1;
         else                             beg[sel] = 1'b0;
         sign[sel] = (load_k >= 0) ? sign_tab[load_k] : 1'($urandom_range(1, 0));
         if (dly_iter >= 0 && cyc > add_c[dly_iter] && cyc <= add_c[dly_iter] + dly)
            ack[sel] = 1'b0;
         else if (noise && wait_k < 0 && cyc < done_c)
            ack[sel] = 1'($urandom_range(1, 0));
         else
            ack[sel] = 1'b1;
      end
      beg[sel] = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST    = 1'b0;
      beg    = 2'b00;
      sign   = 2'b00;
      ack    = 2'b00;
      z0_obs = 32'h0;
      lut[0] = 32'hBF8C9F54;
      for (int i = 1; i < 32; i++) lut[i] = $urandom;

      // Reset state of both instances.
      repeat (3) @(negedge CLK);
      chk_zero(0, "reset25");
      chk_zero(1, "reset32");
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_busy", 64'(busy[0]), 64'd0);

      // Nominal run, ACK tied high, address 0 with SIGN_D=0.
      run(0, 25, -1, 0, 1'b0, -1, 0);
      chk("z0_sign0", 64'(z0_obs), 64'h0000_0000_BF8C_9F54);

      // Address 0 with SIGN_D=1.
      run(0, 25, -1, 0, 1'b0, -1, 1);
      chk("z0_sign1", 64'(z0_obs), 64'h0000_0000_3F8C_9F54);

      // ACK delayed by 5 cycles on iteration 3.
      run(0, 25, 3, 5, 1'b0, -1, -1);

      // Spurious BEG_FSM / ACK_ADD activity during the run and in FIN.
      run(0, 25, -1, 0, 1'b1, -1, -1);

      // Reset in LOAD of iteration 7, then confirm no self-restart.
      run(0, 25, -1, 0, 1'b0, 7, -1);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk($sformatf("post_rst_busy%0d", i), 64'(busy[0]), 64'd0);
         chk($sformatf("post_rst_rom%0d", i), 64'(en_rom1[0]), 64'd0);
      end

      // Fresh run after reset starts again from address 0.
      run(0, 25, -1, 0, 1'b0, -1, -1);

      // Full address space: 32 iterations, no wrap.
      run(1, 32, -1, 0, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
